datapath_bus: RTL and testbench

Register bank and shared bus on the datapath side of the matrix-multiplication processor. Consumes the control word issued each cycle by `control_unit`: one-hot `write_enable`, encoded `read_enable`, `increment`, `alu`. Returns the current instruction and the zero flag. Moves one operand per cycle over a single shared bus between registers, the ALU and data memory, and addresses instruction memory from PC.

---
 rtl/datapath_bus.sv | 242 ++++++++++++++++++++++++
 tb/tb_datapath_bus.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_bus.sv
// datapath_bus: register bank, shared operand bus and ALU for the
// matrix-multiplication processor datapath. One operand moves per cycle
// over the bus. Loads and increments land on the rising edge. Bus, ALU
// result and the data-memory write port are combinational from the
// current control word.
module datapath_bus #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [16:0]       write_enable,
  input  logic [4:0]        read_enable,
  input  logic [5:0]        increment,
  input  logic [2:0]        alu,
  input  logic [16:0]       ins_mem_data,
  input  logic [WIDTH-1:0]  data_mem_rdata,
  output logic [16:0]       instruction,
  output logic              Z,
  output logic [WIDTH-1:0]  bus,
  output logic [ADDR_W-1:0] ins_mem_addr,
  output logic [ADDR_W-1:0] data_mem_addr,
  output logic [WIDTH-1:0]  data_mem_wdata,
  output logic              data_mem_we
);

  localparam int IW = 17;

  // write_enable bit positions
  localparam int WE_DMEM   = 0;
  localparam int WE_ALU_AC = 1;
  localparam int WE_IR_PC  = 2;
  localparam int WE_IR     = 3;
  localparam int WE_AR     = 4;
  localparam int WE_X      = 5;
  localparam int WE_Y      = 6;
  localparam int WE_ZR     = 7;
  localparam int WE_STXY   = 8;
  localparam int WE_STYZ   = 9;
  localparam int WE_STXZ   = 10;
  localparam int WE_R      = 11;
  localparam int WE_R1     = 12;
  localparam int WE_R2     = 13;
  localparam int WE_R3     = 14;
  localparam int WE_DR     = 15;
  localparam int WE_AC     = 16;

  // increment bit positions
  localparam int INC_PC   = 0;
  localparam int INC_AC   = 1;
  localparam int INC_STXY = 2;
  localparam int INC_STXZ = 3;
  localparam int INC_R    = 4;
  localparam int INC_R3   = 5;

  // bus source codes
  localparam logic [4:0] RD_ZERO = 5'd0;
  localparam logic [4:0] RD_INS  = 5'd1;
  localparam logic [4:0] RD_DMEM = 5'd2;
  localparam logic [4:0] RD_PC   = 5'd3;
  localparam logic [4:0] RD_IR   = 5'd4;
  localparam logic [4:0] RD_AR   = 5'd5;
  localparam logic [4:0] RD_AC   = 5'd6;
  localparam logic [4:0] RD_X    = 5'd7;
  localparam logic [4:0] RD_Y    = 5'd8;
  localparam logic [4:0] RD_ZR   = 5'd9;
  localparam logic [4:0] RD_STXY = 5'd10;
  localparam logic [4:0] RD_STYZ = 5'd11;
  localparam logic [4:0] RD_STXZ = 5'd12;
  localparam logic [4:0] RD_R    = 5'd13;
  localparam logic [4:0] RD_R1   = 5'd14;
  localparam logic [4:0] RD_R2   = 5'd15;
  localparam logic [4:0] RD_R3   = 5'd16;
  localparam logic [4:0] RD_DR   = 5'd17;

  // ALU opcodes
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_MUL  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_SFTR = 3'd4;
  localparam logic [2:0] ALU_SFTL = 3'd5;

  logic [ADDR_W-1:0] pc, ar;
  logic [IW-1:0]     ir;
  logic [WIDTH-1:0]  ac, x, y, zr, stxy, styz, stxz, r, r1, r2, r3, dr;
  logic [WIDTH-1:0]  alu_res;

  // Zero-extend an address register onto the bus.
  function automatic logic [WIDTH-1:0] addr_to_bus(input logic [ADDR_W-1:0] a);
    logic [WIDTH+ADDR_W-1:0] t;
    t = {{WIDTH{1'b0}}, a};
    return t[WIDTH-1:0];
  endfunction

  // Place the low bits of a 17-bit instruction word on the bus.
  function automatic logic [WIDTH-1:0] ins_to_bus(input logic [IW-1:0] w);
    logic [WIDTH+IW-1:0] t;
    t = {{WIDTH{1'b0}}, w};
    return t[WIDTH-1:0];
  endfunction

  // Address destinations keep only the low ADDR_W bits of the bus.
  function automatic logic [ADDR_W-1:0] bus_to_addr(input logic [WIDTH-1:0] b);
    logic [WIDTH+ADDR_W-1:0] t;
    t = {{ADDR_W{1'b0}}, b};
    return t[ADDR_W-1:0];
  endfunction

  // Jump target taken from the low bits of IR.
  function automatic logic [ADDR_W-1:0] ir_to_addr(input logic [IW-1:0] w);
    logic [IW+ADDR_W-1:0] t;
    t = {{ADDR_W{1'b0}}, w};
    return t[ADDR_W-1:0];
  endfunction

  // ALU: accumulator against bus operand, all results wrap to WIDTH bits.
  function automatic logic [WIDTH-1:0] alu_op(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op)
      ALU_ADD:  return a + b;
      ALU_MUL:  return prod[WIDTH-1:0];
      ALU_SUB:  return a - b;
      ALU_SFTR: return a >> 1;
      ALU_SFTL: return a << 1;
      default:  return a;
    endcase
  endfunction

  // Shared bus source select; unused codes drive zero.
  always_comb begin
    bus = '0;
    case (read_enable)
      RD_ZERO: bus = '0;
      RD_INS:  bus = ins_to_bus(ins_mem_data);
      RD_DMEM: bus = data_mem_rdata;
      RD_PC:   bus = addr_to_bus(pc);
      RD_IR:   bus = ins_to_bus(ir);
      RD_AR:   bus = addr_to_bus(ar);
      RD_AC:   bus = ac;
      RD_X:    bus = x;
      RD_Y:    bus = y;
      RD_ZR:   bus = zr;
      RD_STXY: bus = stxy;
      RD_STYZ: bus = styz;
      RD_STXZ: bus = stxz;
      RD_R:    bus = r;
      RD_R1:   bus = r1;
      RD_R2:   bus = r2;
      RD_R3:   bus = r3;
      RD_DR:   bus = dr;
      default: bus = '0;
    endcase
  end

  assign alu_res        = alu_op(alu, ac, bus);
  assign data_mem_wdata = bus;
  assign data_mem_we    = write_enable[WE_DMEM];
  assign instruction    = ir;
  assign ins_mem_addr   = pc;
  assign data_mem_addr  = ar;
  assign Z              = (ac == '0);

  // PC: jump from IR wins over sequential increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        pc <= '0;
    else if (write_enable[WE_IR_PC])   pc <= ir_to_addr(ir);
    else if (increment[INC_PC])        pc <= pc + ADDR_W'(1);
  end

  // AR: data memory address, loaded from the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ar <= '0;
    else if (write_enable[WE_AR]) ar <= bus_to_addr(bus);
  end

  // IR: fetched straight from instruction memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ir <= '0;
    else if (write_enable[WE_IR]) ir <= ins_mem_data;
  end

  // AC: bus load beats ALU writeback, which beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ac <= '0;
    else if (write_enable[WE_AC])     ac <= bus;
    else if (write_enable[WE_ALU_AC]) ac <= alu_res;
    else if (increment[INC_AC])       ac <= ac + WIDTH'(1);
  end

  // Plain bus-loaded operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x  <= '0;
      y  <= '0;
      zr <= '0;
      styz <= '0;
      r1 <= '0;
      r2 <= '0;
      dr <= '0;
    end else begin
      if (write_enable[WE_X])    x    <= bus;
      if (write_enable[WE_Y])    y    <= bus;
      if (write_enable[WE_ZR])   zr   <= bus;
      if (write_enable[WE_STYZ]) styz <= bus;
      if (write_enable[WE_R1])   r1   <= bus;
      if (write_enable[WE_R2])   r2   <= bus;
      if (write_enable[WE_DR])   dr   <= bus;
    end
  end

  // STXY: loop index register, bus load beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     stxy <= '0;
    else if (write_enable[WE_STXY]) stxy <= bus;
    else if (increment[INC_STXY])   stxy <= stxy + WIDTH'(1);
  end

  // STXZ: loop index register, bus load beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     stxz <= '0;
    else if (write_enable[WE_STXZ]) stxz <= bus;
    else if (increment[INC_STXZ])   stxz <= stxz + WIDTH'(1);
  end

  // R: counter register, bus load beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r <= '0;
    else if (write_enable[WE_R]) r <= bus;
    else if (increment[INC_R])   r <= r + WIDTH'(1);
  end

  // R3: counter register, bus load beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r3 <= '0;
    else if (write_enable[WE_R3]) r3 <= bus;
    else if (increment[INC_R3])   r3 <= r3 + WIDTH'(1);
  end

endmodule

// File: tb/tb_datapath_bus.sv
// Testbench for datapath_bus: directed vector table, a mid-cycle reset
// sequence, then randomized control words against a register-level model.
module tb_datapath_bus;

  logic        clk;
  logic        rst_n;
  logic [16:0] write_enable;
  logic [4:0]  read_enable;
  logic [5:0]  increment;
  logic [2:0]  alu;
  logic [16:0] ins_mem_data;
  logic [15:0] data_mem_rdata;
  logic [16:0] instruction;
  logic        Z;
  logic [15:0] bus;
  logic [7:0]  ins_mem_addr;
  logic [7:0]  data_mem_addr;
  logic [15:0] data_mem_wdata;
  logic        data_mem_we;

  int total = 0;
  int bad   = 0;

  datapath_bus #(.WIDTH(16), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_enable(write_enable), .read_enable(read_enable),
    .increment(increment), .alu(alu),
    .ins_mem_data(ins_mem_data), .data_mem_rdata(data_mem_rdata),
    .instruction(instruction), .Z(Z), .bus(bus),
    .ins_mem_addr(ins_mem_addr), .data_mem_addr(data_mem_addr),
    .data_mem_wdata(data_mem_wdata), .data_mem_we(data_mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] we;
    logic [4:0]  re;
    logic [5:0]  inc;
    logic [2:0]  op;
    logic [16:0] ins;
    logic [15:0] dm;
    logic [15:0] xbus;
    logic        xz;
    logic [7:0]  xpc;
    logic [7:0]  xar;
    logic [16:0] xir;
  } vec_t;

  vec_t tbl [28];

  // Reference model state: d[0]=AC, 1=X, 2=Y, 3=ZR, 4=STXY, 5=STYZ,
  // 6=STXZ, 7=R, 8=R1, 9=R2, 10=R3, 11=DR (bus code 6+k reads d[k]).
  int unsigned m_pc, m_ar, m_ir;
  int unsigned d [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [16:0] we, input logic [4:0] re,
                              input logic [5:0] inc, input logic [2:0] op,
                              input logic [16:0] ins, input logic [15:0] dm,
                              input logic [15:0] xbus, input logic xz,
                              input logic [7:0] xpc, input logic [7:0] xar,
                              input logic [16:0] xir);
    vec_t v;
    v.we = we; v.re = re; v.inc = inc; v.op = op; v.ins = ins; v.dm = dm;
    v.xbus = xbus; v.xz = xz; v.xpc = xpc; v.xar = xar; v.xir = xir;
    return v;
  endfunction

  task automatic drive(input logic [16:0] we, input logic [4:0] re,
                       input logic [5:0] inc, input logic [2:0] op,
                       input logic [16:0] ins, input logic [15:0] dm);
    write_enable = we; read_enable = re; increment = inc; alu = op;
    ins_mem_data = ins; data_mem_rdata = dm;
  endtask

  task automatic model_clear();
    m_pc = 0; m_ar = 0; m_ir = 0;
    for (int k = 0; k < 12; k++) d[k] = 0;
  endtask

  function automatic int unsigned model_bus(input int unsigned re,
                                            input int unsigned ins,
                                            input int unsigned dm);
    if (re == 1) return ins % 65536;
    if (re == 2) return dm;
    if (re == 3) return m_pc;
    if (re == 4) return m_ir % 65536;
    if (re == 5) return m_ar;
    if (re >= 6 && re <= 17) return d[re-6];
    return 0;
  endfunction

  function automatic int unsigned model_alu(input int unsigned op,
                                            input int unsigned a,
                                            input int unsigned b);
    case (op)
      1: return (a + b) % 65536;
      2: return (a * b) % 65536;
      3: return (a + 65536 - b) % 65536;
      4: return a / 2;
      5: return (a * 2) % 65536;
      default: return a;
    endcase
  endfunction

  // One model-checked cycle: compare outputs before the edge, then advance.
  task automatic mstep(input logic [16:0] we, input logic [4:0] re,
                       input logic [5:0] inc, input logic [2:0] op,
                       input logic [16:0] ins, input logic [15:0] dm);
    int unsigned b, res;
    int unsigned n_pc, n_ar, n_ir;
    int unsigned nd [12];
    int incmap [6];
    drive(we, re, inc, op, ins, dm);
    @(negedge clk);
    b   = model_bus(re, ins, dm);
    res = model_alu(op, d[0], b);
    chk("rnd_bus",   bus,            b);
    chk("rnd_wdata", data_mem_wdata, b);
    chk("rnd_we",    data_mem_we,    we[0]);
    chk("rnd_pc",    ins_mem_addr,   m_pc);
    chk("rnd_ar",    data_mem_addr,  m_ar);
    chk("rnd_ir",    instruction,    m_ir);
    chk("rnd_z",     Z,              (d[0] == 0));
    // next state: increments first, then loads override them
    incmap = '{-1, 0, 4, 6, 7, 10};
    for (int k = 0; k < 12; k++) nd[k] = d[k];
    n_pc = m_pc; n_ar = m_ar; n_ir = m_ir;
    if (inc[0]) n_pc = (m_pc + 1) % 256;
    for (int i = 1; i < 6; i++)
      if (inc[i]) nd[incmap[i]] = (d[incmap[i]] + 1) % 65536;
    if (we[1]) nd[0] = res;
    if (we[2]) n_pc = m_ir % 256;
    if (we[3]) n_ir = ins;
    if (we[4]) n_ar = b % 256;
    for (int bit_i = 5; bit_i <= 15; bit_i++)
      if (we[bit_i]) nd[bit_i-4] = b;
    if (we[16]) nd[0] = b;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ar = n_ar; m_ir = n_ir;
    for (int k = 0; k < 12; k++) d[k] = nd[k];
  endtask

  initial begin
    tbl[0]  = mk(17'h00020, 5'd2,  6'd0, 3'd0, 17'h0,     16'h00AB, 16'h00AB, 1'b1, 8'h00, 8'h00, 17'h0);
    tbl[1]  = mk(17'h03000, 5'd7,  6'd0, 3'd0, 17'h0,     16'h0,    16'h00AB, 1'b1, 8'h00, 8'h00, 17'h0);
    tbl[2]  = mk(17'h00000, 5'd14, 6'd0, 3'd0, 17'h0,     16'h0,    16'h00AB, 1'b1, 8'h00, 8'h00, 17'h0);
    tbl[3]  = mk(17'h00000, 5'd15, 6'd0, 3'd0, 17'h0,     16'h0,    16'h00AB, 1'b1, 8'h00, 8'h00, 17'h0);
    tbl[4]  = mk(17'h00000, 5'd7,  6'd0, 3'd0, 17'h0,     16'h0,    16'h00AB, 1'b1, 8'h00, 8'h00, 17'h0);
    tbl[5]  = mk(17'h00008, 5'd1,  6'd0, 3'd0, 17'h000FF, 16'h0,    16'h00FF, 1'b1, 8'h00, 8'h00, 17'h0);
    tbl[6]  = mk(17'h00004, 5'd4,  6'd0, 3'd0, 17'h0,     16'h0,    16'h00FF, 1'b1, 8'h00, 8'h00, 17'h000FF);
    tbl[7]  = mk(17'h00000, 5'd3,  6'd1, 3'd0, 17'h0,     16'h0,    16'h00FF, 1'b1, 8'hFF, 8'h00, 17'h000FF);
    tbl[8]  = mk(17'h00008, 5'd3,  6'd0, 3'd0, 17'h00042, 16'h0,    16'h0000, 1'b1, 8'h00, 8'h00, 17'h000FF);
    tbl[9]  = mk(17'h00004, 5'd4,  6'd1, 3'd0, 17'h0,     16'h0,    16'h0042, 1'b1, 8'h00, 8'h00, 17'h00042);
    tbl[10] = mk(17'h00000, 5'd3,  6'd0, 3'd0, 17'h0,     16'h0,    16'h0042, 1'b1, 8'h42, 8'h00, 17'h00042);
    tbl[11] = mk(17'h10000, 5'd2,  6'd0, 3'd0, 17'h0,     16'h0005, 16'h0005, 1'b1, 8'h42, 8'h00, 17'h00042);
    tbl[12] = mk(17'h00040, 5'd2,  6'd0, 3'd0, 17'h0,     16'h0005, 16'h0005, 1'b0, 8'h42, 8'h00, 17'h00042);
    tbl[13] = mk(17'h00002, 5'd8,  6'd0, 3'd3, 17'h0,     16'h0,    16'h0005, 1'b0, 8'h42, 8'h00, 17'h00042);
    tbl[14] = mk(17'h00000, 5'd6,  6'd0, 3'd0, 17'h0,     16'h0,    16'h0000, 1'b1, 8'h42, 8'h00, 17'h00042);
    tbl[15] = mk(17'h10000, 5'd2,  6'd0, 3'd0, 17'h0,     16'h8001, 16'h8001, 1'b1, 8'h42, 8'h00, 17'h00042);
    tbl[16] = mk(17'h00002, 5'd0,  6'd0, 3'd5, 17'h0,     16'h0,    16'h0000, 1'b0, 8'h42, 8'h00, 17'h00042);
    tbl[17] = mk(17'h00000, 5'd6,  6'd0, 3'd0, 17'h0,     16'h0,    16'h0002, 1'b0, 8'h42, 8'h00, 17'h00042);
    tbl[18] = mk(17'h10000, 5'd2,  6'd0, 3'd0, 17'h0,     16'h0100, 16'h0100, 1'b0, 8'h42, 8'h00, 17'h00042);
    tbl[19] = mk(17'h00002, 5'd2,  6'd0, 3'd2, 17'h0,     16'h0100, 16'h0100, 1'b0, 8'h42, 8'h00, 17'h00042);
    tbl[20] = mk(17'h00000, 5'd6,  6'd0, 3'd0, 17'h0,     16'h0,    16'h0000, 1'b1, 8'h42, 8'h00, 17'h00042);
    tbl[21] = mk(17'h10002, 5'd2,  6'd2, 3'd5, 17'h0,     16'h0007, 16'h0007, 1'b1, 8'h42, 8'h00, 17'h00042);
    tbl[22] = mk(17'h00000, 5'd6,  6'd0, 3'd0, 17'h0,     16'h0,    16'h0007, 1'b0, 8'h42, 8'h00, 17'h00042);
    tbl[23] = mk(17'h00010, 5'd2,  6'd0, 3'd0, 17'h0,     16'h0010, 16'h0010, 1'b0, 8'h42, 8'h00, 17'h00042);
    tbl[24] = mk(17'h10000, 5'd2,  6'd0, 3'd0, 17'h0,     16'h00FF, 16'h00FF, 1'b0, 8'h42, 8'h10, 17'h00042);
    tbl[25] = mk(17'h00001, 5'd6,  6'd0, 3'd0, 17'h0,     16'h0,    16'h00FF, 1'b0, 8'h42, 8'h10, 17'h00042);
    tbl[26] = mk(17'h00000, 5'd20, 6'd0, 3'd0, 17'h1FFFF, 16'hFFFF, 16'h0000, 1'b0, 8'h42, 8'h10, 17'h00042);
    tbl[27] = mk(17'h00000, 5'd31, 6'd0, 3'd0, 17'h1FFFF, 16'hFFFF, 16'h0000, 1'b0, 8'h42, 8'h10, 17'h00042);

    // power-on reset
    rst_n = 1'b0;
    drive(17'h0, 5'd0, 6'd0, 3'd0, 17'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",  ins_mem_addr,  8'h00);
    chk("rst_ar",  data_mem_addr, 8'h00);
    chk("rst_ir",  instruction,   17'h0);
    chk("rst_z",   Z,             1'b1);
    chk("rst_bus", bus,           16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed table
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].inc, tbl[i].op, tbl[i].ins, tbl[i].dm);
      @(negedge clk);
      chk($sformatf("tbl%0d_bus", i),   bus,            tbl[i].xbus);
      chk($sformatf("tbl%0d_wdata", i), data_mem_wdata, tbl[i].xbus);
      chk($sformatf("tbl%0d_we", i),    data_mem_we,    tbl[i].we[0]);
      chk($sformatf("tbl%0d_z", i),     Z,              tbl[i].xz);
      chk($sformatf("tbl%0d_pc", i),    ins_mem_addr,   tbl[i].xpc);
      chk($sformatf("tbl%0d_ar", i),    data_mem_addr,  tbl[i].xar);
      chk($sformatf("tbl%0d_ir", i),    instruction,    tbl[i].xir);
      @(posedge clk);
      #1;
    end

    // mid-cycle asynchronous reset with X=0x1234 and nonzero PC/AR/IR/AC
    drive(17'h00020, 5'd2, 6'd0, 3'd0, 17'h0, 16'h1234);
    @(posedge clk);
    #1;
    drive(17'h0, 5'd7, 6'd0, 3'd0, 17'h0, 16'h0);
    #1;
    chk("pre_rst_x", bus, 16'h1234);
    rst_n = 1'b0;
    #1;
    chk("arst_x",  bus,           16'h0);
    chk("arst_z",  Z,             1'b1);
    chk("arst_pc", ins_mem_addr,  8'h00);
    chk("arst_ar", data_mem_addr, 8'h00);
    chk("arst_ir", instruction,   17'h0);
    // bus keeps following read_enable during reset
    drive(17'h0, 5'd1, 6'd0, 3'd0, 17'h1ABCD, 16'h0);
    #1;
    chk("arst_bus_ins", bus, 16'hABCD);
    // strobes across an edge in reset are ignored
    drive(17'h1FFFF, 5'd2, 6'h3F, 3'd1, 17'h1ABCD, 16'h5555);
    @(posedge clk);
    #1;
    chk("arst_hold_pc", ins_mem_addr,  8'h00);
    chk("arst_hold_ar", data_mem_addr, 8'h00);
    chk("arst_hold_z",  Z,             1'b1);
    drive(17'h0, 5'd7, 6'd0, 3'd0, 17'h0, 16'h0);
    #1;
    chk("arst_hold_x", bus, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // first load after release, then randomized traffic
    model_clear();
    mstep(17'h00020, 5'd2, 6'd0, 3'd0, 17'h0, 16'h0BEE);
    drive(17'h0, 5'd7, 6'd0, 3'd0, 17'h0, 16'h0);
    #1;
    chk("post_rst_x", bus, 16'h0BEE);
    for (int n = 0; n < 600; n++) begin
      logic [16:0] we;
      logic [5:0]  inc;
      logic [15:0] dm;
      we  = 17'($urandom & $urandom & $urandom);
      inc = 6'($urandom & $urandom);
      dm  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      mstep(we, 5'($urandom_range(0, 31)), inc, 3'($urandom_range(0, 7)),
            17'($urandom), dm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
